grid_renderer: RTL and testbench

- Parametrised, pipelined pixel-colour generator for the battleship board on the VGA output.
- Sits between the VGA timing generator (which supplies `current_row`/`current_line`/`enable`) and the DAC pins.
- Tracks cell index and intra-cell offset with counters, not multipliers, and reads cell status from an external board RAM through an address/data port.
- Draws masked sprites, grid lines and a clipped cursor, at a fixed latency.

---
 rtl/grid_renderer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_grid_renderer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_renderer.sv
// grid_renderer: pipelined pixel-colour generator for the battleship board.
// Pixel (current_row, current_line) presented in cycle t produces cell_addr
// in cycle t+1, expects cell_status in cycle t+2 and drives color_out in
// cycle t+3. Cell index and intra-cell offset come from counters that follow
// the scan coordinates; the row base address is accumulated, not multiplied.
// Optional feature: define GRID_RENDERER_BLINK_EN to blank hit cells on
// alternate groups of BLINK_FRAMES frames.
module grid_renderer #(
    parameter int GRID_COLS    = 10,
    parameter int GRID_ROWS    = 10,
    parameter int CELL_W       = 64,
    parameter int CELL_H       = 48,
    parameter int LINE_W       = 3,
    parameter int STROKE       = 6,
    parameter int CURSOR_R     = 5,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable,
    input  logic [9:0]  current_row,
    input  logic [9:0]  current_line,
    input  logic [9:0]  mouse_pos_x,
    input  logic [9:0]  mouse_pos_y,
    output logic [7:0]  cell_addr,
    input  logic [4:0]  cell_status,
    output logic [11:0] color_out
);
    localparam int OXW = $clog2(CELL_W);
    localparam int OYW = $clog2(CELL_H);
    localparam int CXW = $clog2(GRID_COLS + 1);
    localparam int CYW = $clog2(GRID_ROWS + 1);
    localparam logic [OXW-1:0] OX_LAST  = OXW'(CELL_W - 1);
    localparam logic [OYW-1:0] OY_LAST  = OYW'(CELL_H - 1);
    localparam logic [OXW-1:0] OX_LINE  = OXW'(LINE_W);
    localparam logic [OYW-1:0] OY_LINE  = OYW'(LINE_W);
    localparam logic [CXW-1:0] CX_OUT   = CXW'(GRID_COLS);
    localparam logic [CYW-1:0] CY_OUT   = CYW'(GRID_ROWS);
    localparam logic [7:0]     ROW_STEP = 8'(GRID_COLS);
    localparam logic [10:0]    CUR_R    = 11'(CURSOR_R);

    // Circle ring radii and cross stroke limit.
    localparam int R_CIRC = ((CELL_W < CELL_H) ? CELL_W : CELL_H) / 2 - 2;
    localparam logic signed [10:0] HALF_W = 11'(CELL_W / 2);
    localparam logic signed [10:0] HALF_H = 11'(CELL_H / 2);
    localparam logic signed [21:0] R_OUT2 = 22'(R_CIRC * R_CIRC);
    localparam logic signed [21:0] R_IN2  = 22'((R_CIRC - STROKE) * (R_CIRC - STROKE));
    localparam logic [19:0] CROSS_LIM = 20'(STROKE * CELL_W);

    // Stage 0 state: scan trackers.
    logic [9:0]     prev_row, prev_line;
    logic [OXW-1:0] ox, ox_n;
    logic [OYW-1:0] oy, oy_n;
    logic [CXW-1:0] cx, cx_n;
    logic [CYW-1:0] cy, cy_n;
    logic [7:0]     row_base, row_base_n;

    // Stage 0 combinational results.
    logic [10:0] cdx, cdy, adx, ady;
    logic        cursor_n, line_n, outside_n, blank_n;
    logic [7:0]  addr_n;

    // Pipeline registers.
    logic [OXW-1:0] s1_ox, s2_ox;
    logic [OYW-1:0] s1_oy, s2_oy;
    logic s1_cursor, s1_line, s1_out, s1_en, s1_blank;
    logic s2_cursor, s2_line, s2_out, s2_en, s2_blank;

    // Stage 2 combinational results.
    logic signed [10:0] dx, dy;
    logic signed [21:0] dx2, dy2, d2;
    logic [19:0] prod_a, prod_b, prod_c, diff_a, diff_c;
    logic        circle_on, cross_on;
    logic [11:0] content, pixel;

    // Horizontal tracker: offset wraps per cell, column saturates at GRID_COLS.
    always_comb begin
        ox_n = ox;
        cx_n = cx;
        if (current_row == 10'd0) begin
            ox_n = '0;
            cx_n = '0;
        end else if (current_row != prev_row) begin
            if (ox == OX_LAST) begin
                ox_n = '0;
                if (cx != CX_OUT) cx_n = cx + 1'b1;
            end else begin
                ox_n = ox + 1'b1;
            end
        end
    end

    // Vertical tracker: same rule on lines; row base address moves with cy.
    always_comb begin
        oy_n       = oy;
        cy_n       = cy;
        row_base_n = row_base;
        if (current_line == 10'd0) begin
            oy_n       = '0;
            cy_n       = '0;
            row_base_n = '0;
        end else if (current_line != prev_line) begin
            if (oy == OY_LAST) begin
                oy_n = '0;
                if (cy != CY_OUT) begin
                    cy_n       = cy + 1'b1;
                    row_base_n = row_base + ROW_STEP;
                end
            end else begin
                oy_n = oy + 1'b1;
            end
        end
    end

    // Cursor box, grid-line and outside decisions for the incoming pixel.
    always_comb begin
        cdx       = {1'b0, current_row} - {1'b0, mouse_pos_x};
        cdy       = {1'b0, current_line} - {1'b0, mouse_pos_y};
        adx       = cdx[10] ? (~cdx + 11'd1) : cdx;
        ady       = cdy[10] ? (~cdy + 11'd1) : cdy;
        cursor_n  = (adx <= CUR_R) && (ady <= CUR_R);
        line_n    = ((ox_n < OX_LINE) && (cx_n != '0) && (cx_n < CX_OUT)) ||
                    ((oy_n < OY_LINE) && (cy_n != '0) && (cy_n < CY_OUT));
        outside_n = (cx_n == CX_OUT) || (cy_n == CY_OUT);
        addr_n    = outside_n ? 8'd0 : (row_base_n + 8'(cx_n));
    end

`ifdef GRID_RENDERER_BLINK_EN
    localparam int FCW = $clog2(BLINK_FRAMES + 1);
    localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);
    logic [FCW-1:0] frame_cnt, frame_cnt_n;
    logic           phase, phase_n;

    // Frame counter: a frame starts when the line returns to 0 at row 0.
    always_comb begin
        frame_cnt_n = frame_cnt;
        phase_n     = phase;
        if ((current_line == 10'd0) && (prev_line != 10'd0) && (current_row == 10'd0)) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt_n = '0;
                phase_n     = ~phase;
            end else begin
                frame_cnt_n = frame_cnt + 1'b1;
            end
        end
        blank_n = phase_n;
    end

    // Frame counter and blink phase registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt_n;
            phase     <= phase_n;
        end
    end
`else
    assign blank_n = 1'b0;
`endif

    // Stage 0/1 registers: trackers, registered address and delayed flags.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prev_row  <= '0;
            prev_line <= '0;
            ox        <= '0;
            oy        <= '0;
            cx        <= '0;
            cy        <= '0;
            row_base  <= '0;
            cell_addr <= '0;
            s1_ox     <= '0;
            s1_oy     <= '0;
            s1_cursor <= 1'b0;
            s1_line   <= 1'b0;
            s1_out    <= 1'b0;
            s1_en     <= 1'b0;
            s1_blank  <= 1'b0;
        end else begin
            prev_row  <= current_row;
            prev_line <= current_line;
            ox        <= ox_n;
            oy        <= oy_n;
            cx        <= cx_n;
            cy        <= cy_n;
            row_base  <= row_base_n;
            cell_addr <= addr_n;
            s1_ox     <= ox_n;
            s1_oy     <= oy_n;
            s1_cursor <= cursor_n;
            s1_line   <= line_n;
            s1_out    <= outside_n;
            s1_en     <= enable;
            s1_blank  <= blank_n;
        end
    end

    // Stage 2 registers: hold flags while the RAM answers cell_addr.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s2_ox     <= '0;
            s2_oy     <= '0;
            s2_cursor <= 1'b0;
            s2_line   <= 1'b0;
            s2_out    <= 1'b0;
            s2_en     <= 1'b0;
            s2_blank  <= 1'b0;
        end else begin
            s2_ox     <= s1_ox;
            s2_oy     <= s1_oy;
            s2_cursor <= s1_cursor;
            s2_line   <= s1_line;
            s2_out    <= s1_out;
            s2_en     <= s1_en;
            s2_blank  <= s1_blank;
        end
    end

    // Sprite masks from the cell-local offset.
    always_comb begin
        dx        = $signed(11'(s2_ox)) - HALF_W;
        dy        = $signed(11'(s2_oy)) - HALF_H;
        dx2       = 22'(dx) * 22'(dx);
        dy2       = 22'(dy) * 22'(dy);
        d2        = dx2 + dy2;
        circle_on = (d2 >= R_IN2) && (d2 <= R_OUT2);
        prod_a    = 20'(s2_ox) * 20'(CELL_H);
        prod_c    = 20'(OX_LAST - s2_ox) * 20'(CELL_H);
        prod_b    = 20'(s2_oy) * 20'(CELL_W);
        diff_a    = (prod_a >= prod_b) ? (prod_a - prod_b) : (prod_b - prod_a);
        diff_c    = (prod_c >= prod_b) ? (prod_c - prod_b) : (prod_b - prod_c);
        cross_on  = (diff_a < CROSS_LIM) || (diff_c < CROSS_LIM);
    end

    // Content colour from cell status, then cursor > grid line > content.
    always_comb begin
        content = 12'h000;
        if (s2_out) begin
            content = 12'h2B0;
        end else begin
            case (cell_status)
                5'd1:    content = 12'h555;
                5'd2:    content = s2_blank ? 12'h000 : 12'hE91;
                5'd3:    content = (circle_on && !s2_blank) ? 12'hF0C : 12'h000;
                5'd4:    content = (cross_on && !s2_blank) ? 12'hF0C : 12'h000;
                default: content = 12'h000;
            endcase
        end
        if (s2_cursor)    pixel = 12'hF00;
        else if (s2_line) pixel = 12'h00F;
        else              pixel = content;
    end

    // Stage 3: output register, blanked outside the visible area.
    always_ff @(posedge clk_in) begin
        if (rst_in) color_out <= '0;
        else        color_out <= s2_en ? pixel : 12'h000;
    end
endmodule

// File: tb/tb_grid_renderer.sv
// tb_grid_renderer: scans the board with random holds, enables, mouse
// positions and board contents, and compares cell_addr and color_out
// against a coordinate-arithmetic reference model.
module tb_grid_renderer;
  localparam int GRID_COLS    = 10;
  localparam int GRID_ROWS    = 10;
  localparam int CELL_W       = 64;
  localparam int CELL_H       = 48;
  localparam int LINE_W       = 3;
  localparam int STROKE       = 6;
  localparam int CURSOR_R     = 5;
  localparam int BLINK_FRAMES = 2;
  localparam int RC = ((CELL_W < CELL_H) ? CELL_W : CELL_H) / 2 - 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enable;
  logic [9:0]  current_row, current_line, mouse_pos_x, mouse_pos_y;
  logic [7:0]  cell_addr;
  logic [4:0]  cell_status;
  logic [11:0] color_out;

  grid_renderer #(
    .GRID_COLS(GRID_COLS), .GRID_ROWS(GRID_ROWS), .CELL_W(CELL_W), .CELL_H(CELL_H),
    .LINE_W(LINE_W), .STROKE(STROKE), .CURSOR_R(CURSOR_R), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk_in(clk), .rst_in(rst), .enable(enable),
    .current_row(current_row), .current_line(current_line),
    .mouse_pos_x(mouse_pos_x), .mouse_pos_y(mouse_pos_y),
    .cell_addr(cell_addr), .cell_status(cell_status), .color_out(color_out)
  );

  // Board RAM: one-cycle read latency.
  logic [4:0] board [0:255];
  always @(posedge clk) cell_status <= board[cell_addr];

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  exp_addr_q[$];
  logic        loose_q[$];
  int mouse_x, mouse_y;
  int frame_idx, last_y;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (row=%0d line=%0d)", tag, got, exp,
               current_row, current_line);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int model_cx(input int x);
    int c = x / CELL_W;
    return (c > GRID_COLS) ? GRID_COLS : c;
  endfunction

  function automatic int model_cy(input int y);
    int c = y / CELL_H;
    return (c > GRID_ROWS) ? GRID_ROWS : c;
  endfunction

  function automatic int model_addr(input int x, input int y);
    int cx = model_cx(x);
    int cy = model_cy(y);
    if (cx == GRID_COLS || cy == GRID_ROWS) return 0;
    return cy * GRID_COLS + cx;
  endfunction

  function automatic logic [11:0] model_color(input int x, input int y, input logic en,
                                              input int mx, input int my, input logic blank);
    int cx, cy, ox, oy, st, dx, dy, d2;
    logic outside, line_hit, cur_hit, circ, crs;
    logic [11:0] content;
    cx = model_cx(x);
    cy = model_cy(y);
    ox = x % CELL_W;
    oy = y % CELL_H;
    outside  = (cx == GRID_COLS) || (cy == GRID_ROWS);
    line_hit = (ox < LINE_W && cx >= 1 && cx <= GRID_COLS - 1) ||
               (oy < LINE_W && cy >= 1 && cy <= GRID_ROWS - 1);
    cur_hit  = (iabs(x - mx) <= CURSOR_R) && (iabs(y - my) <= CURSOR_R);
    dx = ox - CELL_W / 2;
    dy = oy - CELL_H / 2;
    d2 = dx * dx + dy * dy;
    circ = (d2 >= (RC - STROKE) * (RC - STROKE)) && (d2 <= RC * RC);
    crs  = (iabs(ox * CELL_H - oy * CELL_W) < STROKE * CELL_W) ||
           (iabs((CELL_W - 1 - ox) * CELL_H - oy * CELL_W) < STROKE * CELL_W);
    st = outside ? 0 : int'(board[cy * GRID_COLS + cx]);
    if (outside) content = 12'h2B0;
    else if (st == 1) content = 12'h555;
    else if (st == 2) content = blank ? 12'h000 : 12'hE91;
    else if (st == 3) content = (circ && !blank) ? 12'hF0C : 12'h000;
    else if (st == 4) content = (crs && !blank) ? 12'hF0C : 12'h000;
    else content = 12'h000;
    if (!en) return 12'h000;
    if (cur_hit) return 12'hF00;
    if (line_hit) return 12'h00F;
    return content;
  endfunction

  // ---------------- driver tasks ----------------
  // Present one pixel for one clock; loose marks a pixel after an
  // out-of-sequence jump, where only "not cursor red" is known.
  task automatic step(input int x, input int y, input logic en, input logic loose);
    logic blank;
    logic [11:0] ec;
    logic [7:0] ea;
    logic lz;
    if (x == 0 && y == 0 && last_y != 0) frame_idx++;
    last_y = y;
`ifdef GRID_RENDERER_BLINK_EN
    blank = ((frame_idx / BLINK_FRAMES) % 2) == 1;
`else
    blank = 1'b0;
`endif
    current_row  = 10'(x);
    current_line = 10'(y);
    enable       = en;
    mouse_pos_x  = 10'(mouse_x);
    mouse_pos_y  = 10'(mouse_y);
    exp_addr_q.push_back(8'(model_addr(x, y)));
    exp_q.push_back(model_color(x, y, en, mouse_x, mouse_y, blank));
    loose_q.push_back(loose);
    @(posedge clk);
    #1;
    ea = exp_addr_q.pop_front();
    if (!loose) check("cell_addr", 12'(cell_addr), 12'(ea));
    if (exp_q.size() > 2) begin
      ec = exp_q.pop_front();
      lz = loose_q.pop_front();
      if (lz) check("cursor_no_wrap", {11'd0, color_out == 12'hF00}, 12'd0);
      else    check("color_out", color_out, ec);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    current_row = '0;
    current_line = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_color", color_out, 12'h000);
    check("reset_addr", 12'(cell_addr), 12'h000);
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    loose_q.delete();
    repeat (2) begin
      exp_q.push_back(12'h000);
      loose_q.push_back(1'b0);
    end
    frame_idx = 0;
    last_y = 0;
  endtask

  task automatic drain(input int x, input int y);
    repeat (3) step(x, y, 1'b0, 1'b0);
  endtask

  // Random scan: lines 0..nlines-1; optionally reset partway through.
  task automatic random_frame(input int nlines, input int reset_line);
    int x, xmax;
    for (int y = 0; y < nlines; y++) begin
      xmax = ($urandom_range(0, 19) == 0) ? 700 : $urandom_range(0, 60);
      mouse_x = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 80) : $urandom_range(0, 1023);
      mouse_y = y + $urandom_range(0, 10) - 5;
      if (mouse_y < 0) mouse_y = 0;
      x = 0;
      while (x <= xmax) begin
        step(x, y, ($urandom_range(0, 9) != 0), 1'b0);
        if (y == reset_line && x == 17) begin
          do_reset();
          return;
        end
        if ($urandom_range(0, 7) != 0) x++;
      end
    end
    drain(0, nlines - 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    enable = 1'b0;
    current_row = '0;
    current_line = '0;
    mouse_x = 400;
    mouse_y = 400;
    mouse_pos_x = '0;
    mouse_pos_y = '0;
    for (int i = 0; i < 256; i++) board[i] = 5'd0;
    board[1]  = 5'd4;   // cross cell
    board[2]  = 5'd3;   // circle cell
    board[21] = 5'd1;   // ship under pixel (100,100)
    board[3]  = 5'd2;
    do_reset();

    // Cursor at the left/top edge, then an out-of-range column.
    mouse_x = 2;
    mouse_y = 0;
    for (int x = 0; x <= 9; x++) step(x, 0, 1'b1, 1'b0);
    step(1020, 0, 1'b1, 1'b1);

    // Directed board frame: sprites in cells 1..3, ship at (100,100), full line 100.
    mouse_x = 400;
    mouse_y = 400;
    for (int y = 0; y <= 100; y++) begin
      int xmax;
      xmax = (y == 100) ? 700 : ((y <= 24) ? 260 : 110);
      for (int x = 0; x <= xmax; x++) step(x, y, 1'b1, 1'b0);
    end
    drain(0, 100);

    // Random boards and scans, including a mid-frame reset.
    for (int i = 0; i < 256; i++)
      board[i] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'(($urandom_range(0, 7)));
    random_frame(300, 250);
    random_frame(520, -1);

    // Short frames over a status-2 cell to exercise the frame counter.
    board[0] = 5'd2;
    mouse_x = 600;
    mouse_y = 600;
    for (int f = 0; f < 5; f++)
      for (int y = 0; y <= 2; y++)
        for (int x = 0; x <= 3; x++) step(x, y, 1'b1, 1'b0);
    drain(0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
